// File: rtl/pclk_mode_pkg.sv
// pclk_mode_pkg: shared FSM states, mode-table layout and the table of pixel-clock PLL settings.
package pclk_mode_pkg;
  typedef enum logic [2:0] {BOOT, LOAD, DRAIN, CFG, PRST, LWAIT, RUN, ERROR} state_t;
  typedef struct packed {
    logic [31:0] n;
    logic [31:0] m;
    logic [31:0] k;
    logic [31:0] c;
  } mode_entry_t;
  localparam int TABLE_DEPTH = 4;
  localparam mode_entry_t MODE_TABLE [TABLE_DEPTH] = '{
    '{32'h00010000, 32'h00000808, 32'h00000000, 32'h00000404},
    '{32'h00000101, 32'h00000F0F, 32'h00000000, 32'h00000505},
    '{32'h00000001, 32'h00000A0A, 32'h00000000, 32'h00000303},
    '{32'h00000001, 32'h00000606, 32'h00000000, 32'h00000202}
  };
  function automatic mode_entry_t mode_lookup(input int unsigned id);
    logic [1:0] idx;
    idx = id[1:0];
    return (id < TABLE_DEPTH) ? MODE_TABLE[idx] : '0;
  endfunction
endpackage

// File: rtl/pclk_mode_rom.sv
// pclk_mode_rom: registered mode-id to PLL-settings lookup.
module pclk_mode_rom
  import pclk_mode_pkg::*;
#(
  parameter int MODE_W    = 3,
  parameter int BOOT_MODE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [MODE_W-1:0] mode,
  output mode_entry_t       entry
);
  always_ff @(posedge clk or posedge rst)
    if (rst) entry <= mode_lookup(BOOT_MODE);
    else entry <= mode_lookup(int'(mode));
endmodule

// File: rtl/pclk_mode_ctrl.sv
// pclk_mode_ctrl: sequences pixel-clock mode switches (drain, PLL reconfig, reset, lock wait, retry).
module pclk_mode_ctrl
  import pclk_mode_pkg::*;
#(
  parameter int MODE_W       = 3,
  parameter int NUM_MODES    = 4,
  parameter int BOOT_MODE    = 0,
  parameter int VID_DRAIN    = 16,
  parameter int CFG_CYCLES   = 64,
  parameter int RST_CYCLES   = 8,
  parameter int LOCK_STABLE  = 256,
  parameter int LOCK_TIMEOUT = 1048576,
  parameter int MAX_RETRY    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [MODE_W-1:0] req_mode,
  output logic              req_ready,
  input  logic              pll_locked,
  output logic              cfg_en,
  output logic              cfg_rst,
  output logic [31:0]       cfg_N,
  output logic [31:0]       cfg_M,
  output logic [31:0]       cfg_K,
  output logic [31:0]       cfg_C,
  output logic              pll_rst,
  output logic              video_rst,
  output logic [MODE_W-1:0] mode_cur,
  output logic              done,
  output logic              err,
  output logic              bad_mode,
  output logic              busy
);
  localparam int CW = $clog2(LOCK_TIMEOUT) + 1;
  localparam int SW = $clog2(LOCK_STABLE) + 1;
  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam logic [MODE_W-1:0] BOOT_ID = MODE_W'(BOOT_MODE);
  state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [SW-1:0] stable, stable_nxt;
  logic [RW-1:0] retry, retry_nxt;
  logic [MODE_W-1:0] target, target_nxt, mode_cur_nxt;
  logic [1:0] sync;
  logic lk, acc, bad_id, same_ok, reconfig, lock_ok, tmo;
  logic cfg_en_d, pll_rst_d, video_rst_d, ready_d, done_d, bad_d, err_d;
  mode_entry_t rom_q;
  assign lk       = sync[1];
  assign acc      = req_valid && req_ready;
  assign bad_id   = int'(req_mode) >= NUM_MODES;
  // a same-mode request is a no-op only while the current lock is still good
  assign same_ok  = state == RUN && req_mode == mode_cur && lk;
  assign reconfig = acc && !bad_id && !same_ok;
  assign lock_ok  = lk && stable == SW'(LOCK_STABLE - 1);
  assign tmo      = cnt == '0;
  pclk_mode_rom #(.MODE_W(MODE_W), .BOOT_MODE(BOOT_MODE)) u_rom (
    .clk(clk), .rst(rst), .mode(target_nxt), .entry(rom_q)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= BOOT;
      cnt <= '0;
      stable <= '0;
      retry <= '0;
      target <= BOOT_ID;
      mode_cur <= BOOT_ID;
      sync <= '0;
      {cfg_N, cfg_M, cfg_K, cfg_C} <= mode_lookup(BOOT_MODE);
      cfg_en <= 1'b0;
      cfg_rst <= 1'b1;
      pll_rst <= 1'b1;
      video_rst <= 1'b1;
      req_ready <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      bad_mode <= 1'b0;
      busy <= 1'b1;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      stable <= stable_nxt;
      retry <= retry_nxt;
      target <= target_nxt;
      mode_cur <= mode_cur_nxt;
      sync <= {sync[0], pll_locked};
      if (state == LOAD) {cfg_N, cfg_M, cfg_K, cfg_C} <= rom_q;
      cfg_en <= cfg_en_d;
      cfg_rst <= 1'b0;
      pll_rst <= pll_rst_d;
      video_rst <= video_rst_d;
      req_ready <= ready_d;
      done <= done_d;
      err <= err_d;
      bad_mode <= bad_d;
      busy <= !ready_d;
    end
  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt - CW'(1);
    stable_nxt = stable;
    retry_nxt = retry;
    target_nxt = target;
    mode_cur_nxt = mode_cur;
    unique case (state)
      BOOT: begin state_nxt = LOAD; target_nxt = BOOT_ID; end
      LOAD: begin state_nxt = DRAIN; cnt_nxt = CW'(VID_DRAIN - 1); end
      DRAIN: if (tmo) begin state_nxt = CFG; cnt_nxt = CW'(CFG_CYCLES - 1); end
      CFG: if (tmo) begin state_nxt = PRST; cnt_nxt = CW'(RST_CYCLES - 1); end
      PRST: if (tmo) begin state_nxt = LWAIT; cnt_nxt = CW'(LOCK_TIMEOUT - 1); stable_nxt = '0; end
      LWAIT: begin
        stable_nxt = lk ? stable + SW'(1) : '0;
        if (lock_ok) begin
          state_nxt = RUN;
          mode_cur_nxt = target;
          retry_nxt = '0;
        end else if (tmo) begin
          retry_nxt = retry + RW'(1);
          state_nxt = (retry_nxt < RW'(MAX_RETRY)) ? LOAD : ERROR;
        end
      end
      RUN: if (!lk) begin
        state_nxt = LWAIT;
        cnt_nxt = CW'(LOCK_TIMEOUT - 1);
        stable_nxt = '0;
        target_nxt = mode_cur;
      end
      default: ;
    endcase
    if (reconfig) begin
      state_nxt = LOAD;
      target_nxt = req_mode;
      retry_nxt = '0;
    end
  end
  // outputs are registered from the next state so they line up with the state register
  always_comb begin
    cfg_en_d = state_nxt == CFG;
    pll_rst_d = state_nxt inside {BOOT, PRST, ERROR};
    video_rst_d = state_nxt != RUN;
    ready_d = state_nxt inside {RUN, ERROR};
    err_d = state_nxt == ERROR;
    done_d = (state == LWAIT && state_nxt == RUN) || (acc && !bad_id && same_ok);
    bad_d = acc && bad_id;
  end
endmodule

// File: tb/tb_pclk_mode_ctrl.sv
// tb_pclk_mode_ctrl: directed self-checking bench for the pixel-clock mode controller.
module tb_pclk_mode_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0;
  logic [2:0] req_mode = 3'd0;
  logic pll_locked = 1'b0;
  logic req_ready, cfg_en, cfg_rst, pll_rst, video_rst, done, err, bad_mode, busy;
  logic [31:0] cfg_N, cfg_M, cfg_K, cfg_C;
  logic [2:0] mode_cur;
  int checks = 0;
  int failures = 0;
  int cyc, cfg_rise, cfg_hi, prst_hi, vr_pre, vr_hi, done_cnt;
  logic cfg_prev = 1'b0;
  logic [31:0] n_seen, m_seen;

  pclk_mode_ctrl #(
    .MODE_W(3), .NUM_MODES(4), .BOOT_MODE(0), .VID_DRAIN(4), .CFG_CYCLES(8),
    .RST_CYCLES(2), .LOCK_STABLE(4), .LOCK_TIMEOUT(32), .MAX_RETRY(3)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_mode(req_mode), .req_ready(req_ready),
    .pll_locked(pll_locked), .cfg_en(cfg_en), .cfg_rst(cfg_rst), .cfg_N(cfg_N), .cfg_M(cfg_M),
    .cfg_K(cfg_K), .cfg_C(cfg_C), .pll_rst(pll_rst), .video_rst(video_rst), .mode_cur(mode_cur),
    .done(done), .err(err), .bad_mode(bad_mode), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    cyc = 0; cfg_rise = 0; cfg_hi = 0; prst_hi = 0; vr_pre = 0; vr_hi = 0; done_cnt = 0;
    n_seen = '0; m_seen = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (cfg_en && !cfg_prev) cfg_rise++;
    if (cfg_en) begin n_seen = cfg_N; m_seen = cfg_M; cfg_hi++; end
    if (pll_rst) prst_hi++;
    if (video_rst && cfg_rise == 0) vr_pre++;
    if (video_rst) vr_hi++;
    if (done) done_cnt++;
    cfg_prev = cfg_en;
  endtask

  task automatic wait_idle(input int maxc);
    int n;
    n = 0;
    do begin step(); n++; end while (busy && n < maxc);
    chk("idle_reached", busy, 1'b0);
  endtask

  task automatic request(input logic [2:0] m);
    req_valid = 1'b1;
    req_mode = m;
    step();
    req_valid = 1'b0;
  endtask

  initial begin
    clr();
    @(posedge clk); @(posedge clk); #1;
    chk("rst_cfg_en", cfg_en, 1'b0);
    chk("rst_pll_rst", pll_rst, 1'b1);
    chk("rst_video_rst", video_rst, 1'b1);
    chk("rst_cfg_rst", cfg_rst, 1'b1);
    chk("rst_busy_ready", {busy, req_ready, done, err, bad_mode}, 5'b10000);
    chk("rst_cfg_N", cfg_N, 32'h00010000);
    chk("rst_mode_cur", mode_cur, 3'd0);
    rst = 1'b0;
    clr();
    for (int i = 0; i < 19; i++) step();
    pll_locked = 1'b1;
    wait_idle(100);
    chk("boot_cycles", cyc, 25);
    chk("boot_cfg_hi", cfg_hi, 8);
    chk("boot_cfg_rise", cfg_rise, 1);
    chk("boot_cfg_M", m_seen, 32'h00000808);
    chk("boot_prst_hi", prst_hi, 2);
    chk("boot_done", done, 1'b1);
    chk("boot_video_rst", video_rst, 1'b0);
    chk("boot_mode_cur", mode_cur, 3'd0);
    chk("boot_ready", req_ready, 1'b1);
    step();
    chk("boot_done_pulse", done, 1'b0);

    clr();
    request(3'd1);
    chk("sw_ready_drop", {req_ready, busy}, 2'b01);
    wait_idle(100);
    chk("sw_cycles", cyc, 20);
    chk("sw_drain_min4", vr_pre >= 4, 1'b1);
    chk("sw_cfg_N", n_seen, 32'h00000101);
    chk("sw_cfg_hi", cfg_hi, 8);
    chk("sw_done", done, 1'b1);
    chk("sw_mode_cur", mode_cur, 3'd1);

    clr();
    pll_locked = 1'b0;
    request(3'd2);
    wait_idle(400);
    chk("to_cycles", cyc, 142);
    chk("to_cfg_pulses", cfg_rise, 3);
    chk("to_err", {err, busy, video_rst, pll_rst, req_ready}, 5'b10111);
    chk("to_mode_cur", mode_cur, 3'd1);
    chk("to_no_done", done_cnt, 0);
    clr();
    pll_locked = 1'b1;
    request(3'd0);
    chk("rec_err_clear", {err, busy}, 2'b01);
    wait_idle(100);
    chk("rec_cycles", cyc, 20);
    chk("rec_done", {done, err}, 2'b10);
    chk("rec_mode_cur", mode_cur, 3'd0);

    step();
    clr();
    pll_locked = 1'b0;
    step(); step(); step();
    pll_locked = 1'b1;
    chk("ll_vrst", {video_rst, busy}, 2'b11);
    wait_idle(50);
    chk("ll_cycles", cyc, 9);
    chk("ll_vr_hi", vr_hi, 6);
    chk("ll_no_cfg", cfg_rise, 0);
    chk("ll_done", done, 1'b1);
    chk("ll_mode_cur", mode_cur, 3'd0);

    step();
    clr();
    request(3'd5);
    chk("bad_pulse", {bad_mode, busy, done}, 3'b100);
    chk("bad_mode_cur", mode_cur, 3'd0);
    step();
    chk("bad_pulse_end", bad_mode, 1'b0);
    request(3'd0);
    chk("same_done", {done, busy, cfg_en}, 3'b100);
    step();
    chk("same_done_end", done, 1'b0);
    chk("same_no_cfg", cfg_rise, 0);

    request(3'd1);
    for (int i = 0; i < 20 && !cfg_en; i++) step();
    chk("mid_in_cfg", cfg_en, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_rst_outs", {cfg_en, pll_rst, video_rst, cfg_rst, busy, req_ready}, 6'b011110);
    chk("mid_rst_cfg_N", cfg_N, 32'h00010000);
    chk("mid_rst_mode_cur", mode_cur, 3'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    clr();
    wait_idle(100);
    chk("mid_boot_cycles", cyc, 20);
    chk("mid_boot_cfg", {cfg_rise[3:0], cfg_hi[7:0]}, {4'd1, 8'd8});
    chk("mid_boot_mode", {done, mode_cur}, {1'b1, 3'd0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
